// File: rtl/pr_vs_pkg.sv
// Shared types and constants for the virtual-socket reconfiguration sequencer.
// Build option PR_TIMEOUT_EN (see pr_vs_sequencer) enables the WAIT_DONE watchdog.
package pr_vs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECOUPLE,
        TRIGGER,
        WAIT_DONE,
        GUARD,
        RELEASE
    } state_t;

    localparam logic VS_SHIFT = 1'b0;
    localparam logic VS_COUNT = 1'b1;

    localparam int CNT_W_DEF       = 24;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int GUARD_CYC_DEF   = 8;
    localparam int TIMEOUT_CYC_DEF = 2000000;

endpackage

// File: rtl/pr_rr_arb2.sv
// Two-requester round-robin arbiter with sticky pending flags.
// A grant clears the winner's flag unless a new pulse for it arrives in the same cycle.
module pr_rr_arb2
    import pr_vs_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_shift,
    input  logic req_count,
    input  logic grant,
    output logic pend_shift,
    output logic pend_count,
    output logic pend_any,
    output logic grant_id
);

    logic last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_shift <= 1'b0;
            pend_count <= 1'b0;
            last_grant <= VS_COUNT;
        end else begin
            pend_shift <= req_shift | (pend_shift & ~(grant && grant_id == VS_SHIFT));
            pend_count <= req_count | (pend_count & ~(grant && grant_id == VS_COUNT));
            if (grant) begin
                last_grant <= grant_id;
            end
        end
    end

    always_comb begin
        pend_any = pend_shift | pend_count;
        if (pend_shift && pend_count) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = pend_count ? VS_COUNT : VS_SHIFT;
        end
    end

endmodule

// File: rtl/pr_vs_sequencer.sv
// Serialises partial reconfiguration of the shift and count sockets over one PR controller.
// Define PR_TIMEOUT_EN to abort WAIT_DONE after TIMEOUT_CYC cycles as if prc_error fired.
module pr_vs_sequencer
    import pr_vs_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int GUARD_CYC   = GUARD_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_shift,
    input  logic             req_count,
    input  logic             prc_done,
    input  logic             prc_error,
    output logic             prc_trigger,
    output logic             prc_trigger_id,
    output logic             vs_shift_decouple,
    output logic             vs_count_decouple,
    output logic             busy,
    output logic             dur_valid,
    output logic             dur_id,
    output logic [CNT_W-1:0] dur_cycles,
    output logic             err_sticky
);

`ifdef PR_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] GUARD_LAST  = 16'(GUARD_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      phase;
    logic             served;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] dur_inc;
    logic [CNT_W-1:0] dur_latched;
    logic             grant;
    logic             grant_id;
    logic             pend_shift;
    logic             pend_count;
    logic             pend_any;
    logic             fail_hit;
    logic             decouple_on;

    pr_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_shift  (req_shift),
        .req_count  (req_count),
        .grant      (grant),
        .pend_shift (pend_shift),
        .pend_count (pend_count),
        .pend_any   (pend_any),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        fail_hit  = 1'b0;
        dur_inc   = (dur == '1) ? dur : dur + CNT_W'(1);
        case (state)
            IDLE: begin
                if (pend_any) begin
                    grant     = 1'b1;
                    state_nxt = DECOUPLE;
                end
            end
            DECOUPLE: begin
                if (phase == SETTLE_LAST) begin
                    state_nxt = TRIGGER;
                end
            end
            TRIGGER: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                // Error beats done; the watchdog only counts when neither arrived.
                fail_hit = prc_error |
                           (TIMEOUT_EN && !prc_done && dur_inc == TIMEOUT_VAL);
                if (prc_done || fail_hit) begin
                    state_nxt = GUARD;
                end
            end
            GUARD: begin
                if (phase == GUARD_LAST) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            served      <= VS_SHIFT;
            dur         <= '0;
            dur_latched <= '0;
            err_sticky  <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= (state_nxt != state) ? 16'd0 : phase + 16'd1;
            if (grant) begin
                served <= grant_id;
            end
            if (state == TRIGGER) begin
                dur <= '0;
            end else if (state == WAIT_DONE) begin
                dur <= dur_inc;
            end
            if (state == WAIT_DONE && state_nxt == GUARD) begin
                dur_latched <= dur_inc;
            end
            if (fail_hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

    always_comb begin
        decouple_on       = state inside {DECOUPLE, TRIGGER, WAIT_DONE, GUARD};
        vs_shift_decouple = decouple_on && served == VS_SHIFT;
        vs_count_decouple = decouple_on && served == VS_COUNT;
        prc_trigger       = state == TRIGGER;
        prc_trigger_id    = prc_trigger & served;
        busy              = state != IDLE;
        dur_valid         = state == GUARD && phase == 16'd0;
        dur_id            = dur_valid & served;
        dur_cycles        = dur_latched;
    end

endmodule
